kgp_multicycle_sequencer: RTL
=============================

Name: kgp_multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for KGP_RISC. It steps the shared datapath through FETCH, DECODE, EXEC, MEM and WB.
- It generates per-state strobes for PC, IR, register file, flags and memory, and resolves branch conditions.
- It handshakes with a shared memory port through mem_ready, with a wait timeout.
- It sits between the IR/flags and the datapath muxes, alongside the opcode-level control decoder.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles to wait for mem_ready in FETCH or MEM before bus error (legal range 1..255).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  opcode field from IR; valid from DECODE onward
- rs_neg  in  1  rs_data[31]
- rs_zero  in  1  rs_data == 0
- carry_flag  in  1  registered ALU carry
- mem_ready  in  1  memory accepted/completed the current request this cycle
- halt_req  in  1  external stop request
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 HALT
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR
- pc_write  out  1  update PC
- pc_sel  out  2  00 pc+1, 01 pc+imm2, 10 label, 11 rs
- reg_write  out  1  register-file write enable
- flags_write  out  1  latch ALU flags
- mem_req  out  1  data memory request
- mem_we  out  1  data memory write (valid with mem_req)
- busy  out  1  state != HALT
- illegal  out  1  sticky: illegal opcode decoded
- bus_error  out  1  sticky: memory timeout
- instr_count  out  CNT_W  retired instructions

Behaviour:
Reset and output timing:
- rst is sampled on the clk edge. Next state = FETCH; wait counter, instr_count, illegal and bus_error are cleared.
- While rst=1, all strobes and pc_sel are 0.
- Strobes are combinational from state, opcode, flags and mem_ready.

FETCH:
- imem_req=1.
- mem_ready=1: ir_write=1, go to DECODE, clear wait counter.
- mem_ready=0 and halt_req=1: go to HALT. mem_ready has priority over halt_req in the same cycle.
- Otherwise the wait counter increments. When it reaches MEM_TIMEOUT with mem_ready still 0: set bus_error, go to HALT.

DECODE:
- Illegal opcodes are 001011, 001100, 001101, 010110–011111 and 100100–111111. On an illegal opcode: set illegal, go to HALT, no strobes.
- Branch opcodes take one cycle here: pc_write=1, then go to FETCH.
- Branch targets and conditions (not taken gives pc_sel=00):
  - br (010010): always taken, pc_sel=11.
  - bltz (010011): taken if rs_neg, pc_sel=01.
  - bz (010100): taken if rs_zero, pc_sel=01.
  - bnz (010101): taken if !rs_zero, pc_sel=01.
  - b (100000): always taken, pc_sel=10.
  - bl (100001): always taken, pc_sel=10, and reg_write=1 in the same cycle.
  - bcy (100010): taken if carry_flag, pc_sel=10.
  - bncy (100011): taken if !carry_flag, pc_sel=10.
- All other legal opcodes go to EXEC.

EXEC:
- ALU opcodes are 000000–001010, 010000 and 010001. For these, flags_write=1 and next state is WB.
- lw (001110) and sw (001111) go to MEM with no flags_write.

MEM:
- mem_req=1; mem_we=1 only for sw.
- Waits on mem_ready with the same timeout rule as FETCH.
- On mem_ready: lw goes to WB; sw asserts pc_write=1 with pc_sel=00, then goes to FETCH.

WB:
- reg_write=1, pc_write=1, pc_sel=00, go to FETCH.

HALT:
- All strobes are 0, busy=0. The block stays in HALT until rst.

instr_count:
- Increments by 1 on every cycle with pc_write=1, including not-taken branches.
- Wraps from all-ones to 0.

Wait counter:
- Cleared on every state change. Only FETCH and MEM count.
- Sized as ceil(log2(MEM_TIMEOUT+1)) bits.

Test Plan:
1. add (000000), mem_ready=1 in the first FETCH cycle -> states 0,1,2,4,0; ir_write, flags_write, reg_write and pc_write each pulse once; instr_count 0→1.
2. lw with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles with mem_we=0, then WB with reg_write=1; total 8 cycles.
3. bz with rs_zero=1 -> DECODE pc_write=1, pc_sel=01. Repeat with rs_zero=0 -> pc_sel=00. Both: no EXEC visit, instr_count +1 each.
4. bl -> same DECODE cycle shows reg_write=1, pc_write=1, pc_sel=10. bncy with carry_flag=1 -> pc_sel=00.
5. opcode 001100 -> illegal=1, state=5, busy=0. Then mem_ready stuck 0 after reset with MEM_TIMEOUT=15 -> bus_error=1 after 15 FETCH cycles. rst clears both flags.
6. halt_req=1 with mem_ready=1 in the same FETCH cycle -> fetch completes to DECODE. halt_req=1 with mem_ready=0 -> HALT next cycle. instr_count wraps 16'hFFFF→0.

Source files
------------

// File: rtl/kgp_multicycle_sequencer.sv
// Multi-cycle instruction sequencer for KGP_RISC.
// Walks the shared datapath through FETCH, DECODE, EXEC, MEM and WB. It drives the
// per-state strobes, resolves branch conditions in DECODE, and guards both memory
// handshakes with a bounded wait that ends in a sticky bus error.
module kgp_multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             rs_neg,
    input  logic             rs_zero,
    input  logic             carry_flag,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_sel,
    output logic             reg_write,
    output logic             flags_write,
    output logic             mem_req,
    output logic             mem_we,
    output logic             busy,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    // Counter value seen during the last cycle a memory request may wait.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] SEL_NEXT  = 2'b00;
    localparam logic [1:0] SEL_IMM   = 2'b01;
    localparam logic [1:0] SEL_LABEL = 2'b10;
    localparam logic [1:0] SEL_RS    = 2'b11;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              set_illegal;
    logic              set_bus_error;

    logic is_alu;
    logic is_illegal;
    logic is_sw;

    assign is_alu     = opcode inside {[6'd0:6'd10], 6'd16, 6'd17};
    assign is_illegal = opcode inside {[6'd11:6'd13], [6'd22:6'd31], [6'd36:6'd63]};
    assign is_sw      = (opcode == 6'b001111);

    assign state = state_q;
    assign busy  = (state_q != S_HALT);

    // Next-state and strobe decode; strobes are forced low while reset is held.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_sel        = SEL_NEXT;
        reg_write     = 1'b0;
        flags_write   = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        set_illegal   = 1'b0;
        set_bus_error = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (halt_req) begin
                    state_d = S_HALT;
                end else if (wait_cnt == WAIT_LAST) begin
                    set_bus_error = 1'b1;
                    state_d       = S_HALT;
                end
            end

            S_DECODE: begin
                if (is_illegal) begin
                    set_illegal = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    // Branches retire here; anything else moves on to EXEC.
                    state_d = S_FETCH;
                    case (opcode)
                        6'b010010: begin pc_write = 1'b1; pc_sel = SEL_RS; end
                        6'b010011: begin pc_write = 1'b1; pc_sel = rs_neg ? SEL_IMM : SEL_NEXT; end
                        6'b010100: begin pc_write = 1'b1; pc_sel = rs_zero ? SEL_IMM : SEL_NEXT; end
                        6'b010101: begin pc_write = 1'b1; pc_sel = !rs_zero ? SEL_IMM : SEL_NEXT; end
                        6'b100000: begin pc_write = 1'b1; pc_sel = SEL_LABEL; end
                        6'b100001: begin pc_write = 1'b1; pc_sel = SEL_LABEL; reg_write = 1'b1; end
                        6'b100010: begin pc_write = 1'b1; pc_sel = carry_flag ? SEL_LABEL : SEL_NEXT; end
                        6'b100011: begin pc_write = 1'b1; pc_sel = !carry_flag ? SEL_LABEL : SEL_NEXT; end
                        default:   state_d = S_EXEC;
                    endcase
                end
            end

            S_EXEC: begin
                if (is_alu) begin
                    flags_write = 1'b1;
                    state_d     = S_WB;
                end else begin
                    // Only lw/sw can reach here besides ALU opcodes.
                    state_d = S_MEM;
                end
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_write = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    set_bus_error = 1'b1;
                    state_d       = S_HALT;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end

            S_HALT:  state_d = S_HALT;

            default: state_d = S_FETCH;
        endcase

        if (rst) begin
            imem_req    = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_sel      = SEL_NEXT;
            reg_write   = 1'b0;
            flags_write = 1'b0;
            mem_req     = 1'b0;
            mem_we      = 1'b0;
        end
    end

    // State, wait counter, sticky error flags and retired-instruction counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q     <= S_FETCH;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (state_q == S_FETCH || state_q == S_MEM) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_bus_error) begin
                bus_error <= 1'b1;
            end
            if (pc_write) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule
